// File: rtl/button_pio_pkg.sv
// rtl/button_pio_pkg.sv - register map and parameter encodings for the button input PIO
package button_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/button_pio_if.sv
// rtl/button_pio_if.sv - Avalon-MM slave port s1 plus interrupt line
interface button_pio_if #(
  parameter int DATA_WIDTH = 8
);

  logic [1:0]            address;
  logic                  chipselect;
  logic                  write_n;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/pio_in_sync.sv
// rtl/pio_in_sync.sv - multi-stage synchronizer bringing asynchronous inputs into clk
module pio_in_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/button_pio.sv
// rtl/button_pio.sv - input PIO with per-bit edge capture, interrupt mask and irq
module button_pio
  import button_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_TYPE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  button_pio_if.slave           s1
);

  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] sync_d;
  logic [DATA_WIDTH-1:0] edge_hit;
  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_cap;
  logic [DATA_WIDTH-1:0] edge_clr;
  logic [DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  irq_next;
  logic                  irq_q;
  logic                  wr;

  pio_in_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (in_port),
    .dout  (sync)
  );

  assign wr = s1.chipselect && !s1.write_n;

  always_comb begin
    edge_hit = sync & ~sync_d;
    case (EDGE_TYPE)
      EDGE_FALL: edge_hit = ~sync & sync_d;
      EDGE_ANY:  edge_hit = sync ^ sync_d;
      default:   edge_hit = sync & ~sync_d;
    endcase
  end

  always_comb begin
    edge_clr = '0;
    if (wr && s1.address == ADDR_EDGE) begin
      edge_clr = s1.writedata;
    end
  end

  // Read mux ignores chipselect: readdata simply tracks address one cycle later.
  always_comb begin
    rd_next = '0;
    case (s1.address)
      ADDR_DATA: rd_next = sync;
      ADDR_MASK: rd_next = irq_mask;
      ADDR_EDGE: rd_next = edge_cap;
      default:   rd_next = '0;
    endcase
  end

  always_comb begin
    if (IRQ_TYPE == IRQ_LEVEL) begin
      irq_next = |(sync & irq_mask);
    end else begin
      irq_next = |(edge_cap & irq_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_d   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      rd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync_d <= sync;
      if (wr && s1.address == ADDR_MASK) begin
        irq_mask <= s1.writedata;
      end
      // Set has priority over clear so an edge coinciding with an ack is not lost.
      edge_cap <= edge_hit | (edge_cap & ~edge_clr);
      rd_q     <= rd_next;
      irq_q    <= irq_next;
    end
  end

  assign s1.readdata = rd_q;
  assign s1.irq      = irq_q;

endmodule

// File: tb/tb_button_pio.sv
// tb/tb_button_pio.sv - self-checking bench for button_pio (rising edge, edge irq)
module tb_button_pio;

  localparam int DW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_port;

  button_pio_if #(.DATA_WIDTH(DW)) bus ();

  button_pio #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (SS),
    .EDGE_TYPE   (0),
    .IRQ_TYPE    (1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .s1      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cs;
    logic       wn;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] inp;
    logic [7:0] erd;
    logic       eirq;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Model: in_port history per clock edge; sync is simply the value sampled SS-1 edges ago.
  logic [7:0] in_hist [0:4095];
  int         cyc    = 0;
  int         rst_at = 0;
  logic [7:0] m_mask, m_edge, m_rd;
  logic       m_irq;

  function automatic logic [7:0] sync_at(int k);
    if (k - (SS - 1) > rst_at) return in_hist[k-SS+1];
    return 8'h00;
  endfunction

  task automatic check(string name, logic [7:0] got, logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic drive(logic rst, logic cs, logic wn, logic [1:0] addr, logic [7:0] wd, logic [7:0] inp);
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = addr;
    bus.writedata  = wd;
    in_port        = inp;
  endtask

  task automatic tick();
    logic [7:0] sy, dd, rise, clr, nrd;
    logic       nirq, wr;
    int         k;
    k = cyc + 1;
    in_hist[k] = in_port;
    if (reset) begin
      m_mask = 8'h00; m_edge = 8'h00; m_rd = 8'h00; m_irq = 1'b0;
      rst_at = k;
    end else begin
      sy   = sync_at(cyc);
      dd   = (cyc > rst_at) ? sync_at(cyc - 1) : 8'h00;
      rise = sy & ~dd;
      wr   = bus.chipselect && !bus.write_n;
      case (bus.address)
        2'd0:    nrd = sy;
        2'd2:    nrd = m_mask;
        2'd3:    nrd = m_edge;
        default: nrd = 8'h00;
      endcase
      nirq   = |(m_edge & m_mask);
      clr    = (wr && bus.address == 2'd3) ? bus.writedata : 8'h00;
      m_edge = rise | (m_edge & ~clr);
      if (wr && bus.address == 2'd2) m_mask = bus.writedata;
      m_rd  = nrd;
      m_irq = nirq;
    end
    @(posedge clk);
    cyc = k;
    #1;
    check("model_rd", bus.readdata, m_rd);
    check("model_irq", {7'd0, bus.irq}, {7'd0, m_irq});
  endtask

  function automatic vec_t mkv(logic cs, logic wn, logic [1:0] addr, logic [7:0] wd,
                               logic [7:0] inp, logic [7:0] erd, logic eirq);
    vec_t v;
    v.cs = cs; v.wn = wn; v.addr = addr; v.wd = wd; v.inp = inp; v.erd = erd; v.eirq = eirq;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    tbl[0]  = mkv(1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[1]  = mkv(1'b0, 1'b1, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b1, 2'd2, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[3]  = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 2'd2, 8'h01, 8'h00, 8'h00, 1'b0);
    tbl[5]  = mkv(1'b0, 1'b1, 2'd2, 8'h00, 8'h01, 8'h01, 1'b0);
    tbl[6]  = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 1'b0);
    tbl[7]  = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 1'b0);
    tbl[8]  = mkv(1'b0, 1'b1, 2'd0, 8'h00, 8'h01, 8'h01, 1'b1);
    tbl[9]  = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h01, 1'b1);
    tbl[10] = mkv(1'b1, 1'b0, 2'd3, 8'h01, 8'h01, 8'h01, 1'b1);
    tbl[11] = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 1'b0);
    tbl[12] = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[13] = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[14] = mkv(1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0);
    tbl[15] = mkv(1'b1, 1'b1, 2'd1, 8'hAA, 8'h00, 8'h00, 1'b0);

    drive(1'b1, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00);
    repeat (3) tick();

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].inp);
      tick();
      check($sformatf("tbl%0d_rd", i), bus.readdata, tbl[i].erd);
      check($sformatf("tbl%0d_irq", i), {7'd0, bus.irq}, {7'd0, tbl[i].eirq});
    end

    // Edge on bit 2 reaches edgecapture on the same clock as its clear.
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h04);
    repeat (2) tick();
    drive(1'b0, 1'b1, 1'b0, 2'd3, 8'h04, 8'h04);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h04);
    tick();
    check("set_wins", bus.readdata, 8'h04);
    check("set_wins_irq", {7'd0, bus.irq}, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'd3, 8'h04, 8'h04);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h04);
    tick();
    check("clr_b2", bus.readdata, 8'h00);

    // Bit 7 captured while masked; unmasking then masking moves only irq.
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h84);
    repeat (4) tick();
    check("cap_b7", bus.readdata, 8'h80);
    check("irq_masked", {7'd0, bus.irq}, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h80, 8'h84);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h84);
    tick();
    check("irq_unmask", {7'd0, bus.irq}, 8'h01);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 8'h84);
    tick();
    check("irq_hold_at_write", {7'd0, bus.irq}, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h84);
    tick();
    check("irq_mask_drop", {7'd0, bus.irq}, 8'h00);
    check("cap_retained", bus.readdata, 8'h80);

    // Inputs already high through reset produce a capture after release.
    drive(1'b1, 1'b0, 1'b1, 2'd3, 8'h00, 8'hFF);
    repeat (3) tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'hFF);
    repeat (3) tick();
    check("rst_cap_lat", bus.readdata, 8'h00);
    tick();
    check("rst_cap_ff", bus.readdata, 8'hFF);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 8'hFF, 8'hFF);
    tick();
    drive(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'hFF);
    tick();
    check("irq_ff", {7'd0, bus.irq}, 8'h01);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h55, 8'hFF);
    tick();
    check("mid_rst_rd", bus.readdata, 8'h00);
    check("mid_rst_irq", {7'd0, bus.irq}, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 8'h00, 8'hFF);
    tick();
    check("mask_cleared", bus.readdata, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] nin;
      nin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in_port;
      drive(($urandom_range(0, 79) == 0), 1'($urandom), 1'($urandom), 2'($urandom),
            8'($urandom), nin);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
